o_buf_drain: RTL and testbench
==============================

// Module: o_buf_drain
// PURPOSE
//  Read-side initiator for the output buffer: walks a finished result tile
//  (num_rows x num_cols) through the O-buffer read port (ram_idx/read_addr ->
//  read data), then writes each 32-bit result word to an external BRAM.
//  The BRAM write uses a valid/ready handshake with row-major byte addressing.
//  Sits between the systolic system's O-buffer read port and the output BRAM
//  as the mirror of the BRAM->A/W buffer load path.
// PARAMETERS
//  ARRAY_N     16       max tile rows (array height)
//  ARRAY_M     16       max tile cols = number of O-buffer column RAMs
//  RAM_SIZE    1<<10    O-buffer RAM depth
//  ADDR_WIDTH  $clog2(RAM_SIZE)  O-buffer address width
//  OUT_WIDTH   32       result word width (fixed 32 for BRAM)
//  RD_LATENCY  1        O-buffer read latency in cycles (>=1)
// PORTS
//  clk              in   1            clock, all logic on rising edge
//  reset            in   1            synchronous, active-high reset
//  start            in   1            begin drain; sampled only in IDLE
//  num_rows         in   $clog2(ARRAY_N)+1  tile rows, 0..ARRAY_N
//  num_cols         in   $clog2(ARRAY_M)+1  tile cols, 0..ARRAY_M
//  o_base_addr      in   ADDR_WIDTH   O-buffer row-0 address
//  bram_base_addr   in   32           byte address of element (0,0)
//  bram_row_stride  in   32           byte stride between rows
//  o_ram_idx        out  $clog2(ARRAY_M)  O-buffer column RAM select
//  o_read_addr      out  ADDR_WIDTH   O-buffer read address
//  o_rd_data        in   OUT_WIDTH    O-buffer read data
//  bram_addr        out  32           BRAM byte address
//  bram_wdata       out  32           BRAM write data
//  bram_we          out  4            byte enables; 4'hF = write valid
//  bram_ready       in   1            BRAM accepts write this cycle
//  busy             out  1            high in ISSUE/WAIT/WRITE
//  done             out  1            one-cycle pulse at tile end
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters and latched config cleared.
//    Reset mid-operation aborts immediately with no done pulse.
//  - Config (dims, bases, stride) is latched on accepted start. Inputs may
//    change afterwards. start while not IDLE is ignored.
//  - Element (r,c) lives in RAM c at o_base_addr+r (ADDR_WIDTH wrap). It is
//    written to bram_base_addr + r*bram_row_stride + c*4 (mod 2^32).
//    Addresses are computed incrementally (row pointer + 4 per col), with
//    no multiplier.
//  - Order: row-major; c inner 0..num_cols-1, r outer 0..num_rows-1.
//  - FSM:
//    IDLE  -start & dims!=0-> ISSUE;  -start & (rows==0|cols==0)-> DONE
//    ISSUE (1 cycle): drive o_ram_idx=c and o_read_addr; go to WAIT.
//    WAIT  (RD_LATENCY cycles): hold the read address.
//          Capture o_rd_data at the end of the last WAIT cycle.
//    WRITE: bram_we=4'hF with registered addr/wdata, held stable until
//          bram_ready=1. On accept: last element -> DONE, else advance
//          r/c -> ISSUE.
//    DONE  (1 cycle): done=1, busy=0, bram_we=0; go to IDLE.
//  - bram_we is 0 outside WRITE; o_ram_idx/o_read_addr hold their last values.
//  - Throughput: (RD_LATENCY+2) cycles per element with bram_ready=1.
//  - Latency: start at T0 -> first write at T0+RD_LATENCY+2.
// TESTING
//  1 2x2 tile, RD_LATENCY=1, ready=1, base=0x100, stride=0x40 -> writes at
//    0x100,0x104,0x140,0x144 at T3,6,9,12; done pulse at T13.
//  2 1x1 tile, ready low 5 cycles in WRITE -> addr/wdata/we stable all 5;
//    single accept; done 1 cycle after.
//  3 num_cols=0 (rows=4) -> no bram_we ever; done at T1; busy stays 0.
//  4 16x16 tile with o_base_addr=RAM_SIZE-2 -> read_addr wraps 1022,1023,0..;
//    256 writes; last to base+15*stride+60.
//  5 reset asserted in the 3rd WAIT of a 4x4 run -> next cycle IDLE, all
//    outputs 0, no done. A new start runs cleanly from (0,0).
//  6 start pulsed while busy with changed dims -> ignored; the original tile
//    completes with its latched config.

Source files
------------

// File: rtl/o_buf_drain.sv
// Output-buffer drain: reads a result tile column-RAM by column-RAM through the
// O-buffer read port and writes each word to BRAM in row-major byte order.
module o_buf_drain #(
    parameter int ARRAY_N    = 16,
    parameter int ARRAY_M    = 16,
    parameter int RAM_SIZE   = 1 << 10,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int OUT_WIDTH  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(ARRAY_N):0]    num_rows,
    input  logic [$clog2(ARRAY_M):0]    num_cols,
    input  logic [ADDR_WIDTH-1:0]       o_base_addr,
    input  logic [31:0]                 bram_base_addr,
    input  logic [31:0]                 bram_row_stride,
    output logic [$clog2(ARRAY_M)-1:0]  o_ram_idx,
    output logic [ADDR_WIDTH-1:0]       o_read_addr,
    input  logic [OUT_WIDTH-1:0]        o_rd_data,
    output logic [31:0]                 bram_addr,
    output logic [31:0]                 bram_wdata,
    output logic [3:0]                  bram_we,
    input  logic                        bram_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int RW = $clog2(ARRAY_N) + 1;
    localparam int CW = $clog2(ARRAY_M) + 1;
    localparam int IW = $clog2(ARRAY_M);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         rows_q, rows_d;
    logic [CW-1:0]         cols_q, cols_d;
    logic [31:0]           stride_q, stride_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]           row_ptr_q, row_ptr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  last_col, last_row;

    assign last_col = (col_q == cols_q - CW'(1));
    assign last_row = (row_q == rows_q - RW'(1));

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        stride_d  = stride_q;
        row_d     = row_q;
        col_d     = col_q;
        rd_addr_d = rd_addr_q;
        row_ptr_d = row_ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        busy      = 1'b0;
        done      = 1'b0;
        bram_we   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d    = num_rows;
                    cols_d    = num_cols;
                    stride_d  = bram_row_stride;
                    row_d     = '0;
                    col_d     = '0;
                    rd_addr_d = o_base_addr;
                    row_ptr_d = bram_base_addr;
                    addr_d    = bram_base_addr;
                    state_d   = (num_rows == '0 || num_cols == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy    = 1'b1;
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (lat_q == LW'(RD_LATENCY - 1)) begin
                    wdata_d = 32'(o_rd_data);
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_WRITE: begin
                busy    = 1'b1;
                bram_we = '1;
                if (bram_ready) begin
                    if (last_col && last_row) begin
                        state_d = S_DONE;
                    end else if (last_col) begin
                        // Row step: byte pointer advances by stride, no multiply.
                        col_d     = '0;
                        row_d     = row_q + RW'(1);
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                        row_ptr_d = row_ptr_q + stride_q;
                        addr_d    = row_ptr_q + stride_q;
                        state_d   = S_ISSUE;
                    end else begin
                        col_d   = col_q + CW'(1);
                        addr_d  = addr_q + 32'd4;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            stride_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rd_addr_q <= '0;
            row_ptr_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            stride_q  <= stride_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_addr_q <= rd_addr_d;
            row_ptr_q <= row_ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_q     <= lat_d;
        end
    end

    assign o_ram_idx   = col_q[IW-1:0];
    assign o_read_addr = rd_addr_q;
    assign bram_addr   = addr_q;
    assign bram_wdata  = wdata_q;

endmodule

// File: tb/tb_o_buf_drain.sv
// Bench for o_buf_drain: table of tiles with hand-derived timing, stall/reset
// sequences, and random tiles checked against an arithmetic address/data model.
module tb_o_buf_drain;

    localparam int ARRAY_N  = 16;
    localparam int ARRAY_M  = 16;
    localparam int RAM_SIZE = 1024;
    localparam int AW       = 10;
    localparam int RDL      = 1;
    localparam int BOUND    = 20000;

    logic          clk = 1'b0;
    logic          reset, start, bram_ready, busy, done;
    logic [4:0]    num_rows, num_cols;
    logic [AW-1:0] o_base_addr, o_read_addr;
    logic [31:0]   bram_base_addr, bram_row_stride, o_rd_data, bram_addr, bram_wdata;
    logic [3:0]    o_ram_idx, bram_we;

    logic [31:0] mem  [ARRAY_M][RAM_SIZE];
    logic [31:0] pipe [RDL];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    o_buf_drain #(
        .ARRAY_N   (ARRAY_N),
        .ARRAY_M   (ARRAY_M),
        .RAM_SIZE  (RAM_SIZE),
        .ADDR_WIDTH(AW),
        .OUT_WIDTH (32),
        .RD_LATENCY(RDL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_rows       (num_rows),
        .num_cols       (num_cols),
        .o_base_addr    (o_base_addr),
        .bram_base_addr (bram_base_addr),
        .bram_row_stride(bram_row_stride),
        .o_ram_idx      (o_ram_idx),
        .o_read_addr    (o_read_addr),
        .o_rd_data      (o_rd_data),
        .bram_addr      (bram_addr),
        .bram_wdata     (bram_wdata),
        .bram_we        (bram_we),
        .bram_ready     (bram_ready),
        .busy           (busy),
        .done           (done)
    );

    // O-buffer model: synchronous read with RDL cycles of latency
    always @(posedge clk) begin
        pipe[0] <= mem[o_ram_idx][o_read_addr];
        for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
    end
    assign o_rd_data = pipe[RDL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ram_idx"}, o_ram_idx, 0);
        chk({tag, "_read_addr"}, o_read_addr, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_wdata"}, bram_wdata, 0);
        chk({tag, "_we"}, bram_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // rmode: 0 = ready always, 1 = random ready, 2 = ready low for the first 5 write cycles
    task automatic run_tile(input int rows, input int cols, input int obase,
                            input logic [31:0] base, input logic [31:0] stride, input int rmode,
                            output int nw, output int done_t, output logic [31:0] last_a);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] sa, sd;
        bit stall, rdy, finished;
        int stalls;
        nw = 0; done_t = -1; last_a = '0; stall = 0; stalls = 0; finished = 0;
        sa = '0; sd = '0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                ea.push_back(32'(base + 32'(r) * stride + 32'(c * 4)));
                ed.push_back(mem[c][(obase + r) % RAM_SIZE]);
            end
        num_rows        = 5'(rows);
        num_cols        = 5'(cols);
        o_base_addr     = AW'(obase);
        bram_base_addr  = base;
        bram_row_stride = stride;
        bram_ready      = 1'b1;
        start           = 1'b1;
        for (int k = 0; k < BOUND && !finished; k++) begin
            @(posedge clk); #1;
            // Config and start are scrambled while busy: the latched tile must be unaffected
            num_rows        = 5'($urandom_range(0, 16));
            num_cols        = 5'($urandom_range(0, 16));
            o_base_addr     = AW'($urandom);
            bram_base_addr  = $urandom;
            bram_row_stride = $urandom;
            start           = (k != 0) && ($urandom_range(0, 3) == 0);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (stalls >= 5);
            endcase
            bram_ready = rdy;
            if (stall) begin
                chk("stall_we", bram_we, 4'hF);
                chk("stall_addr", bram_addr, sa);
                chk("stall_wdata", bram_wdata, sd);
            end
            stall = 0;
            if (bram_we == 4'hF) begin
                if (!rdy) begin
                    stall = 1; sa = bram_addr; sd = bram_wdata; stalls++;
                end else begin
                    chk("busy_in_write", busy, 1);
                    if (ea.size() == 0) chk("extra_write", nw + 1, rows * cols);
                    else begin
                        chk("wr_addr", bram_addr, ea.pop_front());
                        chk("wr_data", bram_wdata, ed.pop_front());
                    end
                    nw++;
                    last_a = bram_addr;
                end
            end else if (bram_we != 4'h0) begin
                chk("we_value", bram_we, 4'h0);
            end
            if (done) begin
                done_t = k + 1;
                chk("busy_at_done", busy, 0);
                chk("we_at_done", bram_we, 0);
                finished = 1;
            end
        end
        start = 1'b0;
        chk("done_timeout", finished, 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("writes_left", ea.size(), 0);
    endtask

    typedef struct {
        int          rows, cols, obase;
        logic [31:0] base, stride;
        int          exp_nw, exp_done;
        logic [31:0] exp_last;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int nw, dt;
        logic [31:0] la;
        int rr, cc;

        tbl[0] = '{2,  2,  0,    32'h100,       32'h40,   4,   13,  32'h144};
        tbl[1] = '{1,  1,  5,    32'h2000,      32'h0,    1,   4,   32'h2000};
        tbl[2] = '{4,  0,  3,    32'h500,       32'h40,   0,   1,   32'h0};
        tbl[3] = '{0,  3,  3,    32'h500,       32'h40,   0,   1,   32'h0};
        tbl[4] = '{16, 16, 1022, 32'h8000_0000, 32'h100,  256, 769, 32'h8000_0F3C};
        tbl[5] = '{3,  5,  10,   32'hFFFF_FFF0, 32'h20,   15,  46,  32'h0000_0040};
        tbl[6] = '{1,  16, 0,    32'h0,         32'h1000, 16,  49,  32'h3C};

        for (int c = 0; c < ARRAY_M; c++)
            for (int a = 0; a < RAM_SIZE; a++) mem[c][a] = $urandom;

        reset = 1'b1; start = 1'b0; bram_ready = 1'b0;
        num_rows = '0; num_cols = '0; o_base_addr = '0;
        bram_base_addr = '0; bram_row_stride = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_tile(tbl[i].rows, tbl[i].cols, tbl[i].obase, tbl[i].base, tbl[i].stride, 0, nw, dt, la);
            chk("tbl_writes", nw, tbl[i].exp_nw);
            chk("tbl_done_t", dt, tbl[i].exp_done);
            chk("tbl_last_addr", la, tbl[i].exp_last);
        end

        // Back-pressure: 1x1 tile with ready held low for 5 write cycles
        run_tile(1, 1, 7, 32'h3000, 32'h10, 2, nw, dt, la);
        chk("stall_writes", nw, 1);
        chk("stall_done_t", dt, 9);
        chk("stall_last_addr", la, 32'h3000);

        // Reset during the third WAIT of a 4x4 tile
        num_rows = 5'd4; num_cols = 5'd4; o_base_addr = AW'(20);
        bram_base_addr = 32'h4000; bram_row_stride = 32'h80;
        bram_ready = 1'b1; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 7) begin
                chk("pre_reset_busy", busy, 1);
                chk("pre_reset_we", bram_we, 0);
                reset = 1'b1;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("midrst");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_reset_done", done, 0);
            chk("post_reset_busy", busy, 0);
        end
        run_tile(4, 4, 20, 32'h4000, 32'h80, 0, nw, dt, la);
        chk("rerun_writes", nw, 16);
        chk("rerun_done_t", dt, 49);
        chk("rerun_last_addr", la, 32'h4000 + 3 * 32'h80 + 12);

        for (int i = 0; i < 8; i++) begin
            rr = $urandom_range(1, 16);
            cc = $urandom_range(1, 16);
            run_tile(rr, cc, $urandom_range(0, RAM_SIZE - 1), $urandom, $urandom, 1, nw, dt, la);
            chk("rand_writes", nw, rr * cc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
